barrel_rot_ctrl: RTL
====================

# barrel_rot_ctrl

Upstream stage for `barrel_shifter`. It accepts a valid/ready stream of WIDE-bit lane vectors grouped into frames and computes a per-beat rotation amount: `select = (offset + k*step) mod PORT` for beat k of the frame. It registers each vector together with its `select` so they can drive `barrel_shifter.data_in`/`select` directly, and it carries full backpressure through a 2-entry skid buffer.

## Interface
Parameters:
- `WIDTH`, 8, bits per port lane
- `PORT`, 8, number of lanes (≥2; need not be a power of two)
- `SHIFT`, `$clog2(PORT)`, width of the rotation amount
- `WIDE`, `WIDTH*PORT`, vector width
- `MAX_BEATS`, 16, maximum beats per frame before forced termination (≥1)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `cfg_offset`  in  SHIFT  starting rotation; sampled on the first beat of each frame
- `cfg_step`  in  SHIFT  rotation increment per beat; sampled on the first beat of each frame
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_data`  in  WIDE  lane vector
- `in_last`  in  1  last beat of frame
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDE  registered copy of `in_data`
- `out_select`  out  SHIFT  rotation for this beat; feeds `barrel_shifter.select`
- `out_last`  out  1  frame end (from `in_last`, or forced)
- `err_overlong`  out  1  sticky: a frame reached MAX_BEATS without `in_last`

## Operation
- FSM states are IDLE (no frame open) and ACTIVE (frame open).
- **IDLE**, on an accepted beat:
  - Latch `off_r = cfg_offset mod PORT` and `step_r = cfg_step mod PORT`. Each reduction is a single conditional subtract of PORT, because the input is always < 2·PORT.
  - The beat's select is `off_r`, and `beat_cnt` becomes 1.
  - If the beat is terminal, stay in IDLE. Otherwise go to ACTIVE.
- **ACTIVE**, on an accepted beat:
  - `select = cur + step_r`. If the sum is ≥ PORT, subtract PORT. Compute the sum in SHIFT+1 bits so it never overflows.
  - `beat_cnt` increments.
- **Terminal beat:** `in_last`=1, or `beat_cnt` reaches MAX_BEATS on this beat.
  - A terminal beat emits `out_last`=1 and returns the FSM to IDLE.
  - A MAX_BEATS termination without `in_last` also sets `err_overlong`. It stays set until `rst`.
  - The next beat starts a new frame at the newly sampled offset, even if the source still considers itself mid-frame.
- `cfg_*` changes while ACTIVE have no effect until the next frame.
- Beats without a handshake do not advance the rotation, the counter or the FSM.
- Data passes through bit-exact. This block never rotates data itself.

## Timing
- Latency: an accepted beat appears at `out_*` on the next cycle when the output is empty or draining. Throughput is 1 beat/cycle under continuous `out_ready`.
- Skid buffer: 2 entries.
  - `in_ready` is a register, high iff the skid entry is empty. There is no combinational `out_ready`→`in_ready` path.
  - Output stall (`out_valid && !out_ready`): `out_*` holds stable. One additional in-flight beat is captured in skid, then `in_ready` drops.
  - When `out_ready` returns: the skid entry moves to the output. `in_ready` rises the following cycle.
- Beats leave in acceptance order. No drop, no duplication.
- Reset values: `out_valid`=0, `in_ready`=1 in the first cycle after reset, `out_data`=0, `out_select`=0, `out_last`=0, `err_overlong`=0, FSM=IDLE, `beat_cnt`=0, skid empty.
- Reset mid-frame or mid-stall discards all held beats. The first accepted beat after reset opens a new frame.
- Simultaneous push and pop on a full output register with an empty skid: the new beat replaces the output and the skid stays empty.

## Structure
- Package `barrel_pkg`:
  - FSM state encoding (IDLE, ACTIVE).
  - A `rot_add(a, b)` function: modulo-PORT add in SHIFT+1 bits with conditional subtract.
  - A `rot_reduce` function: single conditional subtract.
- Sub-module `barrel_skid_buf`: parameter `DW` (= WIDE+SHIFT+1), a 2-entry valid/ready register slice. The top level holds the FSM, the rotation accumulator, `beat_cnt` and `err_overlong`.
- The integration test instantiates `barrel_rot_ctrl` feeding `barrel_shifter` (same WIDTH/PORT).

## Test plan
- **Rotation sequence, no terminal:** PORT=8, offset=3, step=2, 5-beat frame, `out_ready`=1 → `out_select` = 3,5,7,1,3; `out_last` only on beat 5; data matches input; latency 1 cycle.
- **Non-power-of-two ports and config reduction:** PORT=6, offset=7, step=5 → `off_r`=1, `step_r`=5, selects 1,0,5,4. Changing `cfg_step` to 1 mid-frame does not alter the sequence. The next frame uses step 1.
- **Backpressure:** hold `out_ready`=0 for 4 cycles during a continuous 10-beat stream →
  - `out_*` stable while stalled;
  - `in_ready` falls after exactly one extra beat;
  - all 10 beats are delivered in order with the correct selects after release.
- **Overlong frame:** MAX_BEATS=4, 6 beats with `in_last` only on beat 6 →
  - beat 4 has `out_last`=1 and `err_overlong` rises;
  - beats 5–6 restart at `cfg_offset`;
  - `err_overlong` stays 1 until `rst`.
- **Single-beat frames:** `in_last`=1 on every beat, offset=2, step=3 → every `out_select`=2; FSM never enters ACTIVE.
- **Reset during a stalled, half-complete frame:** check reset values next cycle and no stale beat emitted. A new frame's first select equals `cfg_offset`.

Source files
------------

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared FSM encoding and modulo-PORT rotation helpers for barrel_rot_ctrl
package barrel_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  // inputs are always < 2*port, so one conditional subtract is a full reduction
  function automatic int unsigned rot_reduce(input int unsigned v, input int unsigned port);
    return v >= port ? v - port : v;
  endfunction
  function automatic int unsigned rot_add(input int unsigned a, input int unsigned b, input int unsigned port);
    return rot_reduce(a + b, port);
  endfunction
endpackage

// File: rtl/barrel_skid_buf.sv
// barrel_skid_buf: 2-entry valid/ready register slice with registered in_ready
module barrel_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);
  logic [DW-1:0] skid_data;
  logic push;
  assign push = in_valid && in_ready;
  // in_ready low means the skid entry holds a beat
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else if (!out_valid || out_ready) begin
      if (!in_ready) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end
  end
endmodule

// File: rtl/barrel_rot_ctrl.sv
// barrel_rot_ctrl: per-beat rotation amount generator for barrel_shifter with skid-buffered output
module barrel_rot_ctrl
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PORT      = 8,
  parameter int unsigned SHIFT     = $clog2(PORT),
  parameter int unsigned WIDE      = WIDTH * PORT,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SHIFT-1:0] cfg_offset,
  input  logic [SHIFT-1:0] cfg_step,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDE-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDE-1:0]  out_data,
  output logic [SHIFT-1:0] out_select,
  output logic             out_last,
  output logic             err_overlong
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int DW = WIDE + SHIFT + 1;
  state_t state;
  logic [SHIFT-1:0] cur, step_r, sel;
  logic [CW-1:0] beat_cnt, cnt_next;
  logic push, forced, term;
  logic [DW-1:0] buf_out;
  assign push = in_valid && in_ready;
  always_comb begin
    sel      = state == IDLE ? SHIFT'(rot_reduce(32'(cfg_offset), PORT))
                             : SHIFT'(rot_add(32'(cur), 32'(step_r), PORT));
    cnt_next = state == IDLE ? CW'(1) : beat_cnt + CW'(1);
    forced   = cnt_next == CW'(MAX_BEATS);
    term     = in_last || forced;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      step_r       <= '0;
      beat_cnt     <= '0;
      err_overlong <= 1'b0;
    end else if (push) begin
      cur      <= sel;
      beat_cnt <= cnt_next;
      state    <= term ? IDLE : ACTIVE;
      if (state == IDLE) step_r <= SHIFT'(rot_reduce(32'(cfg_step), PORT));
      if (forced && !in_last) err_overlong <= 1'b1;
    end
  end
  barrel_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_data, sel, term}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );
  assign {out_data, out_select, out_last} = buf_out;
endmodule
